// File: rtl/egress_pkg.sv
// Shared types and constants for the egress flit arbiter.
// Holds the flit layout, the arbitration state encoding and small index helpers.
package egress_pkg;

  localparam int PKT_COUNT_BITS   = 32;
  localparam int DEF_INGRESS_BITS = 64;
  localparam int DEF_PAYLOAD_BITS = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Flit as seen by a default-width egress unit.
  typedef struct packed {
    logic                        head;
    logic                        tail;
    logic [DEF_INGRESS_BITS-1:0] ingress_id;
    logic [DEF_PAYLOAD_BITS-1:0] payload;
  } flit_t;

  // Requester index that follows idx in a ring of n requesters.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/egress_flit_arbiter_rr.sv
// Combinational round-robin pick: first requesting index at or after the pointer,
// returned both one-hot and encoded.
module rr_arbiter #(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0]         i_req,
  input  logic [$clog2(N_IN)-1:0] i_ptr,
  output logic [N_IN-1:0]         o_grant_oh,
  output logic [$clog2(N_IN)-1:0] o_grant_idx,
  output logic                    o_any
);

  localparam int IDX_W = $clog2(N_IN);

  int w_idx;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    o_any       = 1'b0;
    o_grant_idx = '0;
    o_grant_oh  = '0;
    w_idx       = 0;
    for (int k = 0; k < N_IN; k++) begin
      w_idx = (int'(i_ptr) + k) % N_IN;
      if (!o_any && i_req[w_idx]) begin
        o_any       = 1'b1;
        o_grant_idx = IDX_W'(w_idx);
      end
    end
    o_grant_oh[o_grant_idx] = o_any;
  end

endmodule

// File: rtl/egress_flit_arbiter.sv
// Packet-granular round-robin arbiter feeding one egress unit through a single
// registered flit slot; also owns the cycle counter and the success/packet stats.
module egress_flit_arbiter
  import egress_pkg::*;
#(
  parameter int N_IN             = 4,
  parameter int INGRESS_BITS     = 64,
  parameter int PAYLOAD_BITS     = 64,
  parameter int CYCLE_COUNT_BITS = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_IN-1:0]                in_valid,
  output logic [N_IN-1:0]                in_ready,
  input  logic [N_IN-1:0]                in_head,
  input  logic [N_IN-1:0]                in_tail,
  input  logic [N_IN*INGRESS_BITS-1:0]   in_ingress_id,
  input  logic [N_IN*PAYLOAD_BITS-1:0]   in_payload,
  output logic [CYCLE_COUNT_BITS-1:0]    cycle_count,
  output logic                           noc_valid,
  output logic                           flit_out_head,
  output logic                           flit_out_tail,
  output logic [INGRESS_BITS-1:0]        flit_out_ingress_id,
  output logic [PAYLOAD_BITS-1:0]        flit_out_payload,
  input  logic                           egressunit_ready,
  input  logic                           egress_success,
  output logic                           success,
  output logic [PKT_COUNT_BITS-1:0]      pkt_count,
  output logic                           proto_err,
  output logic [$clog2(N_IN)-1:0]        grant_id
);

  localparam int IDX_W = $clog2(N_IN);

  typedef struct packed {
    logic                    head;
    logic                    tail;
    logic [INGRESS_BITS-1:0] ingress_id;
    logic [PAYLOAD_BITS-1:0] payload;
  } slot_t;

  arb_state_e                  r_state;
  logic [IDX_W-1:0]            r_owner;
  logic [IDX_W-1:0]            r_rr_ptr;
  logic [IDX_W-1:0]            r_grant;
  logic                        r_valid;
  slot_t                       r_slot;
  logic [CYCLE_COUNT_BITS-1:0] r_cycle_count;
  logic [PKT_COUNT_BITS-1:0]   r_pkt_count;
  logic                        r_success;
  logic                        r_proto_err;

  logic                        w_fire;
  logic                        w_slot_free;
  logic [N_IN-1:0]             w_head_req;
  logic [N_IN-1:0]             w_arb_oh;
  logic [IDX_W-1:0]            w_arb_idx;
  logic                        w_arb_any;
  logic [N_IN-1:0]             w_in_ready;
  logic [IDX_W-1:0]            w_acc_idx;
  logic                        w_accept;
  slot_t                       w_in_flit;
  logic                        w_proto_viol;

  assign w_fire      = r_valid & egressunit_ready;
  assign w_slot_free = ~r_valid | w_fire;
  assign w_head_req  = in_valid & in_head;

  rr_arbiter #(
    .N_IN (N_IN)
  ) u_rr (
    .i_req       (w_head_req),
    .i_ptr       (r_rr_ptr),
    .o_grant_oh  (w_arb_oh),
    .o_grant_idx (w_arb_idx),
    .o_any       (w_arb_any)
  );

  // Only the flit that will be loaded into the slot this cycle ever sees ready.
  always_comb begin
    w_in_ready = '0;
    w_acc_idx  = r_owner;
    if (r_state == IDLE) begin
      w_acc_idx = w_arb_idx;
      if (w_arb_any && w_slot_free) w_in_ready = w_arb_oh;
    end else if (in_valid[r_owner] && w_slot_free) begin
      w_in_ready[r_owner] = 1'b1;
    end
  end

  assign w_accept             = |w_in_ready;
  assign w_in_flit.head       = in_head[w_acc_idx];
  assign w_in_flit.tail       = in_tail[w_acc_idx];
  assign w_in_flit.ingress_id = in_ingress_id[int'(w_acc_idx)*INGRESS_BITS +: INGRESS_BITS];
  assign w_in_flit.payload    = in_payload[int'(w_acc_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];

  // A body flit while idle is refused; a head flit inside a packet is forwarded as data.
  assign w_proto_viol = (r_state == IDLE) ? |(in_valid & ~in_head)
                                          : (w_accept & in_head[r_owner]);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the order of statements below does not matter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_valid  <= 1'b0;
      // NOTE: the flit slot is reset along with its valid bit so the egress unit
      // never sees stale X fields on the bus after reset.
      r_slot   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_slot  <= w_in_flit;
        r_grant <= w_acc_idx;
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_in_flit.tail) begin
              r_rr_ptr <= IDX_W'(next_index(int'(w_acc_idx), N_IN));
            end else begin
              r_state <= LOCKED;
              r_owner <= w_acc_idx;
            end
          end
        end
        LOCKED: begin
          if (w_accept && w_in_flit.tail) begin
            r_state  <= IDLE;
            r_rr_ptr <= IDX_W'(next_index(int'(r_owner), N_IN));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= '0;
      r_pkt_count   <= '0;
      r_success     <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_cycle_count <= r_cycle_count + 1'b1;
      if (w_fire && r_slot.tail && !(&r_pkt_count)) r_pkt_count <= r_pkt_count + 1'b1;
      if (egress_success) r_success <= 1'b1;
      if (w_proto_viol) r_proto_err <= 1'b1;
    end
  end

  assign in_ready            = w_in_ready;
  assign noc_valid           = r_valid;
  assign flit_out_head       = r_slot.head;
  assign flit_out_tail       = r_slot.tail;
  assign flit_out_ingress_id = r_slot.ingress_id;
  assign flit_out_payload    = r_slot.payload;
  assign cycle_count         = r_cycle_count;
  assign pkt_count           = r_pkt_count;
  assign success             = r_success;
  assign proto_err           = r_proto_err;
  assign grant_id            = r_grant;

endmodule

// File: tb/tb_egress_flit_arbiter.sv
// Bench for egress_flit_arbiter: randomized packet traffic checked against a
// transaction-level model of the round-robin / wormhole rules.
module tb_egress_flit_arbiter;

  localparam int N  = 4;
  localparam int IB = 64;
  localparam int PB = 64;
  localparam int CB = 64;
  localparam int IW = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    in_head = '0;
  logic [N-1:0]    in_tail = '0;
  logic [N*IB-1:0] in_ingress_id = '0;
  logic [N*PB-1:0] in_payload = '0;
  logic [CB-1:0]   cycle_count;
  logic            noc_valid;
  logic            flit_out_head;
  logic            flit_out_tail;
  logic [IB-1:0]   flit_out_ingress_id;
  logic [PB-1:0]   flit_out_payload;
  logic            egressunit_ready = 1'b0;
  logic            egress_success = 1'b0;
  logic            success;
  logic [31:0]     pkt_count;
  logic            proto_err;
  logic [IW-1:0]   grant_id;

  always #5 clock = ~clock;

  egress_flit_arbiter #(
    .N_IN(N), .INGRESS_BITS(IB), .PAYLOAD_BITS(PB), .CYCLE_COUNT_BITS(CB)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_head(in_head), .in_tail(in_tail),
    .in_ingress_id(in_ingress_id), .in_payload(in_payload),
    .cycle_count(cycle_count), .noc_valid(noc_valid),
    .flit_out_head(flit_out_head), .flit_out_tail(flit_out_tail),
    .flit_out_ingress_id(flit_out_ingress_id), .flit_out_payload(flit_out_payload),
    .egressunit_ready(egressunit_ready), .egress_success(egress_success),
    .success(success), .pkt_count(pkt_count), .proto_err(proto_err), .grant_id(grant_id)
  );

  typedef struct {
    bit            head;
    bit            tail;
    logic [IB-1:0] id;
    logic [PB-1:0] pay;
  } tflit_t;

  tflit_t q[N][$];
  tflit_t per_sent[N][$];
  tflit_t sent[$];
  tflit_t log_q[$];
  int     vprob, rprob, seq;
  int     n_vec, n_err;

  bit              m_locked, m_valid, m_proto, m_succ;
  int              m_owner, m_rr, m_grant, acc_idx;
  tflit_t          m_slot;
  longint unsigned m_pkt, m_cyc;
  logic [N-1:0]    exp_ready;

  task automatic add_pkt(input int i, input int len, input bit stray_heads);
    tflit_t f;
    for (int k = 0; k < len; k++) begin
      f.head = (k == 0) || (stray_heads && $urandom_range(19) == 0);
      f.tail = (k == len - 1);
      f.id   = {8'(i), 24'(seq), 32'($urandom)};
      f.pay  = {32'($urandom), 32'($urandom)};
      seq++;
      q[i].push_back(f);
      per_sent[i].push_back(f);
      sent.push_back(f);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    in_valid = '0;
    egress_success = 1'b0;
    egressunit_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      per_sent[i].delete();
    end
    sent.delete();
    log_q.delete();
    m_locked = 0; m_valid = 0; m_proto = 0; m_succ = 0;
    m_owner = 0; m_rr = 0; m_grant = 0; m_pkt = 0; m_cyc = 0;
    m_slot = '{0, 0, '0, '0};
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0 && $urandom_range(99) < vprob) begin
        in_valid[i] = 1'b1;
        in_head[i]  = q[i][0].head;
        in_tail[i]  = q[i][0].tail;
        in_ingress_id[i*IB +: IB] = q[i][0].id;
        in_payload[i*PB +: PB]    = q[i][0].pay;
      end else begin
        in_valid[i] = 1'b0;
        in_head[i]  = 1'($urandom_range(1));
        in_tail[i]  = 1'($urandom_range(1));
        in_ingress_id[i*IB +: IB] = {32'($urandom), 32'($urandom)};
        in_payload[i*PB +: PB]    = {32'($urandom), 32'($urandom)};
      end
    end
    egressunit_ready = ($urandom_range(99) < rprob);
  endtask

  // Which requester the rules allow to hand over a flit right now, if any.
  function automatic void model_eval();
    bit sf;
    int i;
    sf = !m_valid || egressunit_ready;
    exp_ready = '0;
    acc_idx = -1;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (acc_idx < 0 && in_valid[i] && in_head[i]) acc_idx = i;
      end
      if (!sf) acc_idx = -1;
    end else if (in_valid[m_owner] && sf) begin
      acc_idx = m_owner;
    end
    if (acc_idx >= 0) exp_ready[acc_idx] = 1'b1;
  endfunction

  function automatic void model_clock();
    bit fire;
    tflit_t f;
    fire = m_valid && egressunit_ready;
    if (fire && m_slot.tail && m_pkt < 64'hFFFF_FFFF) m_pkt++;
    if (!m_locked && |(in_valid & ~in_head)) m_proto = 1;
    if (m_locked && acc_idx >= 0 && in_head[m_owner]) m_proto = 1;
    if (acc_idx >= 0) begin
      f.head = in_head[acc_idx];
      f.tail = in_tail[acc_idx];
      f.id   = in_ingress_id[acc_idx*IB +: IB];
      f.pay  = in_payload[acc_idx*PB +: PB];
      m_slot = f;
      m_valid = 1;
      m_grant = acc_idx;
      if (!m_locked) begin
        if (!f.tail) begin
          m_locked = 1;
          m_owner = acc_idx;
        end else begin
          m_rr = (acc_idx + 1) % N;
        end
      end else if (f.tail) begin
        m_locked = 0;
        m_rr = (m_owner + 1) % N;
      end
    end else if (fire) begin
      m_valid = 0;
    end
    if (egress_success) m_succ = 1;
    m_cyc++;
  endfunction

  task automatic cycle();
    tflit_t o;
    drive();
    #1;
    model_eval();
    n_vec++;
    if (in_ready !== exp_ready) begin
      n_err++;
      $display("FAIL in_ready t=%0t got %b want %b", $time, in_ready, exp_ready);
    end
    if (noc_valid && egressunit_ready) begin
      o.head = flit_out_head; o.tail = flit_out_tail;
      o.id = flit_out_ingress_id; o.pay = flit_out_payload;
      log_q.push_back(o);
    end
    @(posedge clock);
    model_clock();
    if (acc_idx >= 0) void'(q[acc_idx].pop_front());
    @(negedge clock);
    n_vec++;
    if (noc_valid !== m_valid) begin
      n_err++;
      $display("FAIL noc_valid t=%0t got %b want %b", $time, noc_valid, m_valid);
    end
    if (m_valid) begin
      n_vec++;
      if ({flit_out_head, flit_out_tail, flit_out_ingress_id, flit_out_payload} !==
          {m_slot.head, m_slot.tail, m_slot.id, m_slot.pay}) begin
        n_err++;
        $display("FAIL flit t=%0t got %b%b %h %h want %b%b %h %h", $time, flit_out_head,
                 flit_out_tail, flit_out_ingress_id, flit_out_payload, m_slot.head,
                 m_slot.tail, m_slot.id, m_slot.pay);
      end
    end
    n_vec++;
    if (pkt_count !== 32'(m_pkt) || grant_id !== IW'(m_grant) || proto_err !== m_proto ||
        success !== m_succ || cycle_count !== m_cyc) begin
      n_err++;
      $display("FAIL status t=%0t got pkt=%0d gnt=%0d perr=%b succ=%b cyc=%0d want %0d %0d %b %b %0d",
               $time, pkt_count, grant_id, proto_err, success, cycle_count,
               m_pkt, m_grant, m_proto, m_succ, m_cyc);
    end
  endtask

  task automatic check_log_vs_sent(input string name, input int cnt);
    n_vec++;
    if (log_q.size() != cnt) begin
      n_err++;
      $display("FAIL %s flit count got %0d want %0d", name, log_q.size(), cnt);
    end
    for (int j = 0; j < cnt && j < log_q.size(); j++) begin
      n_vec++;
      if (log_q[j].id !== sent[j].id || log_q[j].pay !== sent[j].pay ||
          log_q[j].tail !== sent[j].tail) begin
        n_err++;
        $display("FAIL %s order[%0d] got id %h want id %h", name, j, log_q[j].id, sent[j].id);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vprob = 100; rprob = 100;
    #1;
    n_vec++;
    if (cycle_count !== '0 || noc_valid !== 1'b0 || pkt_count !== '0 || success !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got cyc=%0d v=%b pkt=%0d s=%b want 0 0 0 0",
               cycle_count, noc_valid, pkt_count, success);
    end
    for (int k = 1; k < 10; k++) begin
      cycle();
      n_vec++;
      if (cycle_count !== CB'(k) || noc_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle cyc got %0d v=%b want %0d v=0", cycle_count, noc_valid, k);
      end
    end
  endtask

  task automatic test_two_packets();
    apply_reset();
    vprob = 100; rprob = 100;
    add_pkt(0, 3, 0);
    add_pkt(2, 3, 0);
    repeat (8) cycle();
    check_log_vs_sent("two_pkts", 6);
    n_vec++;
    if (pkt_count !== 32'd2 || grant_id !== IW'(2)) begin
      n_err++;
      $display("FAIL two_pkts got pkt=%0d gnt=%0d want 2 2", pkt_count, grant_id);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    vprob = 100; rprob = 100;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) add_pkt(i, 1, 0);
    repeat (9) cycle();
    n_vec++;
    if (log_q.size() != 8) begin
      n_err++;
      $display("FAIL rr throughput got %0d flits want 8", log_q.size());
    end
    for (int j = 0; j < 8 && j < log_q.size(); j++) begin
      n_vec++;
      if (log_q[j].id[IB-1 -: 8] !== 8'(j % N) || log_q[j].id !== sent[j].id) begin
        n_err++;
        $display("FAIL rr order[%0d] got src %0d want %0d", j, log_q[j].id[IB-1 -: 8], j % N);
      end
    end
    n_vec++;
    if (pkt_count !== 32'd8) begin
      n_err++;
      $display("FAIL rr pkt_count got %0d want 8", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    vprob = 100; rprob = 100;
    add_pkt(1, 5, 0);
    repeat (2) cycle();
    rprob = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_vec++;
      if (flit_out_ingress_id !== sent[1].id || flit_out_payload !== sent[1].pay ||
          in_ready[1] !== 1'b0 || noc_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall hold got id %h rdy %b want id %h rdy 0",
                 flit_out_ingress_id, in_ready[1], sent[1].id);
      end
    end
    rprob = 100;
    repeat (5) cycle();
    check_log_vs_sent("stall", 5);
    n_vec++;
    if (pkt_count !== 32'd1) begin
      n_err++;
      $display("FAIL stall pkt_count got %0d want 1", pkt_count);
    end
  endtask

  task automatic test_proto_err();
    tflit_t f;
    apply_reset();
    vprob = 100; rprob = 100;
    f = '{0, 0, 64'h0100_0000_dead_beef, 64'h1234};
    q[1].push_back(f);
    repeat (3) begin
      cycle();
      n_vec++;
      if (in_ready[1] !== 1'b0 || proto_err !== 1'b1 || noc_valid !== 1'b0) begin
        n_err++;
        $display("FAIL proto_idle got rdy=%b perr=%b v=%b want 0 1 0", in_ready[1], proto_err, noc_valid);
      end
    end
    q[1].delete();
    repeat (3) cycle();
    n_vec++;
    if (proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL proto_sticky got %b want 1", proto_err);
    end
  endtask

  task automatic test_reset_midpacket();
    apply_reset();
    vprob = 100; rprob = 100;
    add_pkt(3, 4, 0);
    repeat (2) cycle();
    n_vec++;
    if (noc_valid !== 1'b1 || grant_id !== IW'(3)) begin
      n_err++;
      $display("FAIL locked3 got v=%b gnt=%0d want 1 3", noc_valid, grant_id);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (noc_valid !== 1'b0 || grant_id !== '0 || cycle_count !== '0) begin
      n_err++;
      $display("FAIL async_reset got v=%b gnt=%0d cyc=%0d want 0 0 0", noc_valid, grant_id, cycle_count);
    end
    apply_reset();
    add_pkt(2, 1, 0);
    add_pkt(0, 1, 0);
    repeat (3) cycle();
    n_vec++;
    if (log_q.size() != 2 || log_q[0].id !== sent[1].id || log_q[1].id !== sent[0].id) begin
      n_err++;
      $display("FAIL post_reset order got %0d flits, want src 0 then src 2", log_q.size());
    end
    egress_success = 1'b1;
    n_vec++;
    if (success !== 1'b0) begin
      n_err++;
      $display("FAIL success early got %b want 0", success);
    end
    cycle();
    egress_success = 1'b0;
    n_vec++;
    if (success !== 1'b1) begin
      n_err++;
      $display("FAIL success set got %b want 1", success);
    end
    repeat (2) cycle();
    n_vec++;
    if (success !== 1'b1) begin
      n_err++;
      $display("FAIL success sticky got %b want 1", success);
    end
  endtask

  task automatic test_random();
    tflit_t e;
    int src;
    apply_reset();
    vprob = 70; rprob = 60;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 3) add_pkt(i, int'($urandom_range(4, 1)), 1);
      egress_success = ($urandom_range(99) == 0);
      cycle();
    end
    egress_success = 1'b0;
    vprob = 100; rprob = 100;
    repeat (60) cycle();
    n_vec++;
    if (log_q.size() != sent.size() || noc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random drain got %0d flits v=%b want %0d v=0", log_q.size(), noc_valid, sent.size());
    end
    for (int j = 0; j < log_q.size(); j++) begin
      src = int'(log_q[j].id[IB-1 -: 8]);
      n_vec++;
      if (src >= N || per_sent[src].size() == 0) begin
        n_err++;
        $display("FAIL random src[%0d] got unexpected src %0d", j, src);
      end else begin
        e = per_sent[src].pop_front();
        if (log_q[j].id !== e.id || log_q[j].pay !== e.pay || log_q[j].head !== e.head) begin
          n_err++;
          $display("FAIL random seq[%0d] got id %h want id %h", j, log_q[j].id, e.id);
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; seq = 0;
    test_reset();
    test_two_packets();
    test_round_robin();
    test_backpressure();
    test_proto_err();
    test_reset_midpacket();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
